// File: rtl/insn_fetch_ctrl.sv
// insn_fetch_ctrl
// ---------------
// Fetch sequencer for a synchronous-read instruction memory (one-cycle
// read latency). It owns the fetch PC and issues at most one tracked read
// per cycle. Returned words go into a 2-entry queue that is presented to
// decode through a valid/ready handshake. The block supports start from a
// boot address, redirect with squash of stale words, and halt with drain.
//
// Ports
//   clk             clock; all state updates on posedge
//   rst             asynchronous active-low reset
//   start           one-cycle pulse; begin fetching at boot_addr (IDLE/HALT only)
//   boot_addr       first fetch address after start
//   redirect_valid  redirect request (RUN/DRAIN only)
//   redirect_addr   new fetch address
//   halt_req        stop issuing new fetches (RUN only)
//   mem_addr        memory read address (always equals pc)
//   mem_rdata       memory read data, valid one cycle after mem_addr
//   out_valid       head of queue holds a fetched word
//   out_ready       decode accepts the head word
//   out_insn        head-of-queue instruction
//   out_pc          address the head instruction was fetched from
//   halted          high in HALT
module insn_fetch_ctrl #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MEM_INSN_ADDR-1:0] boot_addr,
  input  logic                     redirect_valid,
  input  logic [MEM_INSN_ADDR-1:0] redirect_addr,
  input  logic                     halt_req,
  output logic [MEM_INSN_ADDR-1:0] mem_addr,
  input  logic [LEN_INSN-1:0]      mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LEN_INSN-1:0]      out_insn,
  output logic [MEM_INSN_ADDR-1:0] out_pc,
  output logic                     halted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } state_t;

  state_t                   state_q, state_d;
  logic [MEM_INSN_ADDR-1:0] pc_q, pc_d;
  logic [MEM_INSN_ADDR-1:0] tag_q, tag_d;
  logic                     inflight_q, inflight_d;

  // Queue: entry "hd" is the head, entry "tl" sits behind it.
  logic [1:0]               count_q, count_d;
  logic [LEN_INSN-1:0]      hd_insn_q, hd_insn_d, tl_insn_q, tl_insn_d;
  logic [MEM_INSN_ADDR-1:0] hd_pc_q, hd_pc_d, tl_pc_q, tl_pc_d;

  logic       start_ok;
  logic       redir;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign mem_addr  = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_insn  = hd_insn_q;
  assign out_pc    = hd_pc_q;
  assign halted    = (state_q == HALT);

  assign start_ok = start && ((state_q == IDLE) || (state_q == HALT));
  assign redir    = redirect_valid && ((state_q == RUN) || (state_q == DRAIN));
  assign pop      = out_valid && out_ready;
  // A redirect squashes the word returning this cycle.
  assign push     = inflight_q && !redir;

  // Credit: queued + inflight words, less the one leaving now, must stay
  // below the queue depth so every issued read has a slot on return.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && !redir && !halt_req &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  // Control: state, pc, inflight tracking
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    tag_d      = issue ? pc_q : tag_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          pc_d    = boot_addr;
        end
      end
      RUN: begin
        if (redir) begin
          pc_d = redirect_addr;
        end else begin
          if (halt_req) begin
            state_d = DRAIN;
          end
          if (issue) begin
            pc_d = pc_q + MEM_INSN_ADDR'(1);
          end
        end
      end
      DRAIN: begin
        if (redir) begin
          pc_d = redirect_addr;
        end
        if (!inflight_q) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (start_ok) begin
          state_d = RUN;
          pc_d    = boot_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue update. Shift-style FIFO: a pop moves the tail into the head, a
  // push lands in the first free slot after that shift. A redirect empties
  // the queue after any pop of the same edge; stale data is left in place
  // but is never presented because out_valid follows count.
  always_comb begin
    count_d   = count_q;
    hd_insn_d = hd_insn_q;
    hd_pc_d   = hd_pc_q;
    tl_insn_d = tl_insn_q;
    tl_pc_d   = tl_pc_q;

    if (redir) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            hd_insn_d = mem_rdata;
            hd_pc_d   = tag_q;
          end else begin
            tl_insn_d = mem_rdata;
            tl_pc_d   = tag_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          hd_insn_d = tl_insn_q;
          hd_pc_d   = tl_pc_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            hd_insn_d = mem_rdata;
            hd_pc_d   = tag_q;
          end else begin
            hd_insn_d = tl_insn_q;
            hd_pc_d   = tl_pc_q;
            tl_insn_d = mem_rdata;
            tl_pc_d   = tag_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      hd_insn_q  <= '0;
      hd_pc_q    <= '0;
      tl_insn_q  <= '0;
      tl_pc_q    <= '0;
    end else begin
      assert (!(push && !pop && (count_q == 2'd2)));
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      hd_insn_q  <= hd_insn_d;
      hd_pc_q    <= hd_pc_d;
      tl_insn_q  <= tl_insn_d;
      tl_pc_q    <= tl_pc_d;
    end
  end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// tb_insn_fetch_ctrl
// ------------------
// Directed bench for insn_fetch_ctrl. A synchronous memory model returns
// (addr XOR 0xA5A5_0000) one cycle after mem_addr. Expected fetch PCs are
// pushed to a scoreboard queue as each fetch phase is started; each
// accepted output word is popped and compared (pc and instruction).
module tb_insn_fetch_ctrl;

  localparam int W = 32;
  localparam int A = 10;

  logic         clk;
  logic         rst;
  logic         start;
  logic [A-1:0] boot_addr;
  logic         redirect_valid;
  logic [A-1:0] redirect_addr;
  logic         halt_req;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_insn;
  logic [A-1:0] out_pc;
  logic         halted;

  int nchecks = 0;
  int nerrors = 0;
  logic [A-1:0] sb[$];

  insn_fetch_ctrl #(
    .LEN_INSN      (W),
    .MEM_INSN_ADDR (A)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .boot_addr      (boot_addr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  function automatic logic [W-1:0] exp_word(input logic [A-1:0] a);
    return {{(W-A){1'b0}}, a} ^ 32'hA5A5_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= exp_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake on the falling edge, let the rising
  // edge pass, then score any word that was transferred on it.
  task automatic tick();
    logic         xfer;
    logic [A-1:0] opc;
    logic [W-1:0] oins;
    logic [A-1:0] epc;
    @(negedge clk);
    xfer = out_valid && out_ready;
    opc  = out_pc;
    oins = out_insn;
    @(posedge clk);
    #1;
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 64'(sb.size()), 64'd1);
      end else begin
        epc = sb.pop_front();
        chk("sb_out_pc", 64'(opc), 64'(epc));
        chk("sb_out_insn", 64'(oins), 64'(exp_word(epc)));
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    boot_addr      = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_insn", 64'(out_insn), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_mem_addr", 64'(mem_addr), 64'd0);

    // Start at 0x010, streaming with out_ready=1
    boot_addr = 10'h010;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();                                   // edge 0
    start = 1'b0;
    chk("lat_e0_valid", 64'(out_valid), 64'd0);
    chk("lat_e0_mem_addr", 64'(mem_addr), 64'h010);
    for (int i = 0; i < 5; i++) sb.push_back(A'(10'h010 + i));
    tick();                                   // edge 1: first issue
    chk("lat_e1_valid", 64'(out_valid), 64'd0);
    tick();                                   // edge 2: first capture
    chk("lat_e2_valid", 64'(out_valid), 64'd1);
    chk("lat_e2_pc", 64'(out_pc), 64'h010);
    repeat (3) tick();                        // 0x010..0x012 delivered

    // Backpressure: queue fills to 2, outputs held, no further issue
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc_held", 64'(out_pc), 64'h013);
      chk("bp_insn_held", 64'(out_insn), 64'(exp_word(10'h013)));
    end
    chk("bp_mem_addr", 64'(mem_addr), 64'h015);
    out_ready = 1'b1;
    repeat (2) tick();                        // 0x013, 0x014 delivered

    // Redirect to 0x200 with 0x015 queued and 0x016 inflight
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 10'h200;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("redir_flush_valid", 64'(out_valid), 64'd0);
    chk("redir_mem_addr", 64'(mem_addr), 64'h200);
    chk("redir_sb_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 5; i++) sb.push_back(A'(10'h200 + i));
    tick();
    chk("redir_e1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("redir_e2_valid", 64'(out_valid), 64'd1);
    chk("redir_e2_pc", 64'(out_pc), 64'h200);
    repeat (3) tick();                        // 0x200..0x202 delivered

    // Halt with out_ready=0: drain inflight, then HALT; queue kept
    out_ready = 1'b0;
    halt_req  = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("drain_halted", 64'(halted), 64'd0);
    chk("drain_pc", 64'(out_pc), 64'h203);
    tick();
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_mem_addr", 64'(mem_addr), 64'h205);
    chk("halt_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();                        // 0x203, 0x204 delivered
    chk("halt_empty_valid", 64'(out_valid), 64'd0);
    chk("halt_sb_empty", 64'(sb.size()), 64'd0);
    tick();
    chk("halt_sticky", 64'(halted), 64'd1);

    // Restart from HALT at 0x040
    boot_addr = 10'h040;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 3; i++) sb.push_back(A'(10'h040 + i));
    tick();
    tick();
    chk("restart_valid", 64'(out_valid), 64'd1);
    chk("restart_pc", 64'(out_pc), 64'h040);
    repeat (3) tick();                        // 0x040..0x042 delivered
    chk("pre_rst_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-stream
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_pc", 64'(out_pc), 64'd0);
    chk("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 64'(out_valid), 64'd0);
    end
    chk("post_rst_halted", 64'(halted), 64'd0);

    // PC wrap from 0x3FE
    boot_addr = 10'h3FE;
    start     = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(10'h3FE);
    sb.push_back(10'h3FF);
    sb.push_back(10'h000);
    sb.push_back(10'h001);
    tick();
    tick();
    chk("wrap_first_pc", 64'(out_pc), 64'h3FE);
    repeat (4) tick();
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
